// File: rtl/pc_sequencer.sv
// Fetch PC register with next-PC selection (seq/branch/jump/jr/call/ret) and a circular return-address stack.
// Latency: next-PC is combinational from pc and controls, registered on the rising clk edge (1 cycle).
// Backpressure: stall=1 freezes pc, RAS and sticky error flags regardless of pc_sel.
module pc_sequencer #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall,
    input  logic [2:0]       pc_sel,
    input  logic [15:0]      branch_offset,
    input  logic [25:0]      jump_target,
    input  logic [WIDTH-1:0] jr_address,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] ras_top,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             err_overflow,
    output logic             err_underflow,
    output logic             err_misalign
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(RAS_DEPTH);
    localparam logic [WIDTH-1:0] LOW28_MSK = WIDTH'(28'hFFF_FFFF);

    typedef enum logic [2:0] {
        SEL_SEQ    = 3'd0,
        SEL_BRANCH = 3'd1,
        SEL_JUMP   = 3'd2,
        SEL_JR     = 3'd3,
        SEL_CALL   = 3'd4,
        SEL_RET    = 3'd5
    } pc_sel_e;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d, top_idx;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d, unf_q, unf_d, mis_q, mis_d;
    logic             push_en;

    logic [WIDTH-1:0] branch_tgt, jump_tgt, jr_tgt;
    logic             jr_misaligned;

    assign pc_plus4      = pc_q + WIDTH'(4);
    assign branch_tgt    = pc_plus4 + ({{(WIDTH-16){branch_offset[15]}}, branch_offset} << 2);
    // Upper bits beyond the 28-bit jump region come from pc+4 (region splice).
    assign jump_tgt      = (pc_plus4 & ~LOW28_MSK) | WIDTH'({jump_target, 2'b00});
    assign jr_tgt        = {jr_address[WIDTH-1:2], 2'b00};
    assign jr_misaligned = (jr_address[1:0] != 2'b00);

    assign top_idx   = ptr_q - PTR_W'(1);
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == DEPTH_C);
    assign ras_top   = ras_empty ? '0 : ras_q[top_idx];

    assign pc            = pc_q;
    assign err_overflow  = ovf_q;
    assign err_underflow = unf_q;
    assign err_misalign  = mis_q;

    // Next-PC select plus RAS pointer/count and sticky-flag updates.
    always_comb begin
        pc_d    = pc_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        mis_d   = mis_q;
        push_en = 1'b0;
        if (!stall) begin
            case (pc_sel_e'(pc_sel))
                SEL_BRANCH: pc_d = branch_tgt;
                SEL_JUMP:   pc_d = jump_tgt;
                SEL_JR: begin
                    pc_d = jr_tgt;
                    if (jr_misaligned) mis_d = 1'b1;
                end
                SEL_CALL: begin
                    pc_d    = jump_tgt;
                    push_en = 1'b1;
                    ptr_d   = ptr_q + PTR_W'(1);
                    // A push while full overwrites the oldest slot; depth stays saturated.
                    if (ras_full) ovf_d = 1'b1;
                    else          cnt_d = cnt_q + CNT_W'(1);
                end
                SEL_RET: begin
                    if (!ras_empty) begin
                        pc_d  = ras_q[top_idx];
                        ptr_d = top_idx;
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        // Empty stack: fall back to the register target.
                        pc_d  = jr_tgt;
                        unf_d = 1'b1;
                        if (jr_misaligned) mis_d = 1'b1;
                    end
                end
                default: pc_d = pc_plus4;
            endcase
        end
    end

    // PC, RAS control and sticky error registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q  <= RESET_VECTOR;
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            mis_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            mis_q <= mis_d;
        end
    end

    // RAS storage: link address written at the current pointer on a call.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
        end else if (push_en) begin
            ras_q[ptr_q] <= pc_plus4;
        end
    end

endmodule
